// File: rtl/mul_pkg.sv
// Shared definitions for the sequential multiplier: FSM encoding and default operand width.
package mul_pkg;

    localparam int unsigned MUL_WIDTH_DEFAULT = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } mul_state_e;

endpackage

// File: rtl/multiplicador_seq.sv
// Sequential shift-and-add multiplier: one multiplier bit per clock, WIDTH RUN cycles,
// then a one-cycle DONE with produto loaded on the DONE-entry edge.
// Optional feature: define MUL_SIGNED_EN for two's-complement operands (magnitudes are
// multiplied, the result is negated when the signs differ; latency is the same).
module multiplicador_seq
    import mul_pkg::*;
#(
    parameter int unsigned WIDTH = MUL_WIDTH_DEFAULT
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               mul,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] produto
);

    localparam int unsigned CntW = $clog2(WIDTH) + 1;
    localparam logic [CntW-1:0] LastBit = CntW'(WIDTH - 1);

    mul_state_e         state_q, state_d;
    logic               mul_q;
    logic               start;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [2*WIDTH-1:0] mcand_q, mcand_d;
    logic [WIDTH-1:0]   mplier_q, mplier_d;
    logic [CntW-1:0]    cnt_q, cnt_d;
    logic               neg_q, neg_d;
    logic [2*WIDTH-1:0] produto_q, produto_d;

    logic [WIDTH-1:0]   mag_a, mag_b;
    logic               op_neg;
    logic [2*WIDTH-1:0] sum;

    // Rising edge of the request; gated by rst so nothing looks busy while held in reset.
    always_comb begin
        start = mul & ~mul_q & ~rst;
    end

    // Operand conditioning: magnitudes and result sign for the selected number format.
    always_comb begin
`ifdef MUL_SIGNED_EN
        mag_a  = a[WIDTH-1] ? (~a + 1'b1) : a;
        mag_b  = b[WIDTH-1] ? (~b + 1'b1) : b;
        op_neg = a[WIDTH-1] ^ b[WIDTH-1];
`else
        mag_a  = a;
        mag_b  = b;
        op_neg = 1'b0;
`endif
    end

    // FSM next state, datapath next state and handshake outputs.
    always_comb begin
        state_d   = state_q;
        acc_d     = acc_q;
        mcand_d   = mcand_q;
        mplier_d  = mplier_q;
        cnt_d     = cnt_q;
        neg_d     = neg_q;
        produto_d = produto_q;
        sum       = acc_q + (mplier_q[0] ? mcand_q : '0);
        busy      = 1'b0;
        done      = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    // Stall control from the request cycle itself.
                    busy     = 1'b1;
                    mcand_d  = {{WIDTH{1'b0}}, mag_a};
                    mplier_d = mag_b;
                    acc_d    = '0;
                    cnt_d    = '0;
                    neg_d    = op_neg;
                    state_d  = RUN;
                end
            end
            RUN: begin
                busy     = 1'b1;
                acc_d    = sum;
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q + 1'b1;
                if (cnt_q == LastBit) begin
                    // Last bit: publish the finished product on the same edge.
                    produto_d = neg_q ? (~sum + 1'b1) : sum;
                    state_d   = DONE;
                end
            end
            DONE: begin
                // Requests arriving here are dropped, not queued.
                done    = 1'b1;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            mul_q     <= 1'b0;
            acc_q     <= '0;
            mcand_q   <= '0;
            mplier_q  <= '0;
            cnt_q     <= '0;
            neg_q     <= 1'b0;
            produto_q <= '0;
        end else begin
            state_q   <= state_d;
            mul_q     <= mul;
            acc_q     <= acc_d;
            mcand_q   <= mcand_d;
            mplier_q  <= mplier_d;
            cnt_q     <= cnt_d;
            neg_q     <= neg_d;
            produto_q <= produto_d;
        end
    end

    assign produto = produto_q;

endmodule

// File: doc/multiplicador_seq.md
MULTIPLICADOR_SEQ -- requirements
Module: multiplicador_seq

Interface
REQ-001 The block SHALL have parameter WIDTH, default 16, giving the operand width in bits.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-004 The block SHALL have port mul, input, 1 bit: multiply request from the control unit, held high while opcode 15 is decoded.
REQ-005 The block SHALL have ports a and b, input, WIDTH bits each: operands, valid in the cycle the request is accepted.
REQ-006 The block SHALL have port busy, output, 1 bit: stall to control, high while a multiply is in progress.
REQ-007 The block SHALL have port done, output, 1 bit: single-cycle completion pulse.
REQ-008 The block SHALL have port produto, output, 2*WIDTH bits: the last completed product.

Function
REQ-009 The block SHALL implement FSM states IDLE, RUN and DONE.
REQ-010 The block SHALL register mul into mul_q each cycle; start = mul & ~mul_q.
REQ-011 A level-held mul SHALL start exactly one multiply.
REQ-012 In IDLE with start=1, the next edge (E0) SHALL capture a and b, clear the accumulator, clear the bit counter and enter RUN.
REQ-013 In RUN, each edge SHALL process one multiplier bit by shift-and-add and increment the counter.
REQ-014 After WIDTH RUN edges, the block SHALL enter DONE and load produto on that same edge (E0+WIDTH).
REQ-015 DONE SHALL last exactly one cycle; done=1 only in DONE; the next edge SHALL return to IDLE.
REQ-016 busy SHALL equal (state==RUN) | (state==IDLE & start), combinational, so that control stalls from the request cycle onward.
REQ-017 busy SHALL be 0 in DONE.
REQ-018 start SHALL be ignored in RUN and DONE; a rising edge of mul in those states SHALL be lost and not queued.
REQ-019 a and b SHALL be sampled only at E0; changes during RUN SHALL have no effect.
REQ-020 produto SHALL hold its value until the next DONE.
REQ-021 The full product SHALL be exact in 2*WIDTH bits with no truncation; the low WIDTH bits are the register-file result.
REQ-022 The counter SHALL be clog2(WIDTH)+1 bits wide and SHALL NOT wrap during a multiply.

Reset
REQ-023 rst=1 SHALL force IDLE, mul_q=0, accumulator=0, counter=0, produto=0, busy=0 and done=0 immediately, with no clock required.
REQ-024 Reset during RUN SHALL abort the multiply with no produto update.
REQ-025 If mul=1 when rst falls, the first edge SHALL see start=1 and begin a multiply.

Configuration
REQ-026 With MUL_SIGNED_EN defined, a and b SHALL be two's complement: magnitudes are multiplied and produto is negated at DONE when the operand signs differ, with latency unchanged.
REQ-027 Without MUL_SIGNED_EN, a and b SHALL be unsigned.

Structure
REQ-028 Package mul_pkg SHALL hold the state encoding (IDLE=2'd0, RUN=2'd1, DONE=2'd2) and the default WIDTH constant.
REQ-029 No sub-module is required; edge detection, FSM and datapath SHALL live in one module.

Verification
REQ-030 Unsigned: a=3, b=5, one-cycle mul pulse -> busy high from the request cycle; done at E0+16; produto=32'h0000000F.
REQ-031 Unsigned: a=16'hFFFF, b=16'hFFFF -> produto=32'hFFFE0001.
REQ-032 MUL_SIGNED_EN defined: a=-7 (16'hFFF9), b=3 -> produto=32'hFFFFFFEB; a=-4, b=-4 -> 32'h00000010.
REQ-033 mul held high for 40 cycles -> exactly one done pulse and one produto update.
REQ-034 rst pulsed at the 5th RUN cycle -> busy=0, done=0 and produto=0 immediately; no later done.
REQ-035 a and b changed every cycle during RUN -> produto reflects the values captured at E0 only.
